// File: rtl/btn_event_sched.sv
// rtl/btn_event_sched.sv - debounced button levels to press/release/long event stream
// Purpose: per-button edge and long-press detection, round-robin arbitration of
//          pending events into a small FIFO drained over a valid/ready handshake.
// Ports:
//   clk_i        system clock, rising edge
//   arst_n_i     asynchronous active-low reset
//   deb_i        debounced button levels, 1 = pressed
//   evt_valid_o  FIFO head holds an event
//   evt_ready_i  consumer takes the head this cycle
//   evt_data_o   [7:6] type (01 press, 10 release, 11 long), [5:0] button index
//   overflow_o   sticky: an event was dropped
//   clr_ovf_i    synchronous clear of overflow_o
// Optional feature macro: BTN_EVT_LONG_PRESS_EN (long-press counters and type 11 events)
module btn_event_sched #(
  parameter int NUM_BTN       = 2,
  parameter int CLK_FREQ      = 50_000_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic [NUM_BTN-1:0] deb_i,
  output logic               evt_valid_o,
  input  logic               evt_ready_i,
  output logic [7:0]         evt_data_o,
  output logic               overflow_o,
  input  logic               clr_ovf_i
);

  localparam int LONG_CYCLES = (CLK_FREQ / 1000) * LONG_PRESS_MS;
  localparam int IDX_W       = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  // Elaboration-time range guard; an illegal configuration yields an empty named block.
  if (NUM_BTN < 1 || NUM_BTN > 64 || FIFO_DEPTH < 2 || LONG_CYCLES < 1) begin : g_bad_params
  end

  logic                           arm_q;
  logic [NUM_BTN-1:0]             prev_q;
  logic [NUM_BTN-1:0]             press_pend_q, press_pend_d;
  logic [NUM_BTN-1:0]             long_pend_q, long_pend_d;
  logic [NUM_BTN-1:0]             rel_pend_q, rel_pend_d;
  logic [IDX_W-1:0]               rr_q, rr_d;
  logic                           ovf_q, ovf_d;

  logic [FIFO_DEPTH-1:0][7:0]     mem_q;
  logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]               count_q;

  logic [NUM_BTN-1:0]             rise, fall, long_hit;
  logic [NUM_BTN-1:0]             req, gnt_oh;
  logic [NUM_BTN-1:0]             srv_press, srv_long, srv_rel;
  logic [NUM_BTN-1:0]             p_keep, l_keep, r_keep;
  logic                           grant_vld;
  logic [IDX_W-1:0]               grant_idx;
  int                             cand;
  logic [1:0]                     evt_type;
  logic [7:0]                     evt_code;
  logic                           fifo_full, push, pop, ovf_evt;

  // Edges are suppressed until prev_q holds a real sample of deb_i.
  assign rise = arm_q ? (deb_i & ~prev_q) : '0;
  assign fall = arm_q ? (~deb_i & prev_q) : '0;

`ifdef BTN_EVT_LONG_PRESS_EN
  localparam int LC_W = $clog2(LONG_CYCLES + 1);

  logic [NUM_BTN-1:0][LC_W-1:0] cnt_q, cnt_d;

  // Saturating at LONG_CYCLES means LONG_CYCLES-1 is passed only once per press.
  always_comb begin
    cnt_d    = cnt_q;
    long_hit = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      if (!arm_q || !deb_i[b]) begin
        cnt_d[b] = '0;
      end else begin
        long_hit[b] = (cnt_q[b] == LC_W'(LONG_CYCLES - 1));
        if (cnt_q[b] != LC_W'(LONG_CYCLES)) begin
          cnt_d[b] = cnt_q[b] + LC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign long_hit = '0;
`endif

  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign evt_valid_o = (count_q != '0);
  assign evt_data_o  = mem_q[rd_ptr_q];
  assign overflow_o  = ovf_q;
  assign pop         = evt_valid_o & evt_ready_i;
  assign push        = grant_vld;

  // Round-robin search starting at rr_q; nothing is granted while the FIFO is full.
  always_comb begin
    req       = press_pend_q | long_pend_q | rel_pend_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (!fifo_full) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        cand = int'(rr_q) + i;
        if (cand >= NUM_BTN) begin
          cand = cand - NUM_BTN;
        end
        if (!grant_vld && req[cand[IDX_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[IDX_W-1:0];
        end
      end
    end
  end

  // Oldest flag first: a press always precedes its long, a long precedes its release.
  always_comb begin
    evt_type = 2'b10;
    if (press_pend_q[grant_idx]) begin
      evt_type = 2'b01;
    end else if (long_pend_q[grant_idx]) begin
      evt_type = 2'b11;
    end
  end

  assign evt_code  = {evt_type, 6'(grant_idx)};
  assign gnt_oh    = grant_vld ? (NUM_BTN'(1) << grant_idx) : '0;
  assign srv_press = gnt_oh & press_pend_q;
  assign srv_long  = gnt_oh & ~press_pend_q & long_pend_q;
  assign srv_rel   = gnt_oh & ~press_pend_q & ~long_pend_q & rel_pend_q;

  // A flag being served this cycle may be re-set by a new event without loss.
  assign p_keep = press_pend_q & ~srv_press;
  assign l_keep = long_pend_q & ~srv_long;
  assign r_keep = rel_pend_q & ~srv_rel;

  assign press_pend_d = p_keep | rise;
  assign long_pend_d  = l_keep | long_hit;
  assign rel_pend_d   = r_keep | fall;

  assign ovf_evt = |((rise & p_keep) | (long_hit & l_keep) | (fall & r_keep));
  // A new drop outranks a simultaneous clear.
  assign ovf_d   = ovf_evt | (ovf_q & ~clr_ovf_i);

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (int'(grant_idx) == NUM_BTN - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      arm_q        <= 1'b0;
      prev_q       <= '0;
      press_pend_q <= '0;
      long_pend_q  <= '0;
      rel_pend_q   <= '0;
      rr_q         <= '0;
      ovf_q        <= 1'b0;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      arm_q        <= 1'b1;
      prev_q       <= deb_i;
      press_pend_q <= press_pend_d;
      long_pend_q  <= long_pend_d;
      rel_pend_q   <= rel_pend_d;
      rr_q         <= rr_d;
      ovf_q        <= ovf_d;
      if (push) begin
        mem_q[wr_ptr_q] <= evt_code;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_sched.sv
// tb/tb_btn_event_sched.sv - self-checking bench for btn_event_sched
module tb_btn_event_sched;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [1:0] deb;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_data;
  logic       overflow;
  logic       clr_ovf;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [1:0] deb;
    logic       push;
    logic [7:0] evt;
    logic       exp_valid;
  } vec_t;

  vec_t arm_tbl[11];

  always #5 clk = ~clk;

  btn_event_sched #(
    .NUM_BTN      (2),
    .CLK_FREQ     (10_000),
    .LONG_PRESS_MS(1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .deb_i       (deb),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .evt_data_o  (evt_data),
    .overflow_o  (overflow),
    .clr_ovf_i   (clr_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard pop at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (arst_n && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt: got %0h expected none", evt_data);
      end else begin
        chk("evt_data", evt_data, sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && (sb.size() != 0 || evt_valid); i++) tick();
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_valid", evt_valid, 0);
  endtask

  initial begin
    arst_n    = 1'b0;
    deb       = 2'b11;
    evt_ready = 1'b1;
    clr_ovf   = 1'b0;

    for (int i = 0; i < 5; i++) arm_tbl[i] = '{2'b11, 1'b0, 8'h00, 1'b0};
    arm_tbl[5]  = '{2'b10, 1'b1, 8'h80, 1'b0};
    arm_tbl[6]  = '{2'b10, 1'b0, 8'h00, 1'b1};
    arm_tbl[7]  = '{2'b10, 1'b0, 8'h00, 1'b0};
    arm_tbl[8]  = '{2'b00, 1'b1, 8'h81, 1'b0};
    arm_tbl[9]  = '{2'b00, 1'b0, 8'h00, 1'b1};
    arm_tbl[10] = '{2'b00, 1'b0, 8'h00, 1'b0};

    ticks(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_data", evt_data, 8'h00);
    chk("rst_ovf", overflow, 0);

    // Buttons held through reset: no press, later releases are reported.
    arst_n = 1'b1;
    for (int r = 0; r < 11; r++) begin
      deb = arm_tbl[r].deb;
      if (arm_tbl[r].push) sb.push_back(arm_tbl[r].evt);
      tick();
      chk($sformatf("arm_valid[%0d]", r), evt_valid, arm_tbl[r].exp_valid);
      chk($sformatf("arm_ovf[%0d]", r), overflow, 0);
    end
    drain(5);

    // Short press on btn1 with latency check.
    deb = 2'b10;
    sb.push_back(8'h41);
    tick();
    chk("press_lat1_valid", evt_valid, 0);
    tick();
    chk("press_lat2_valid", evt_valid, 1);
    chk("press_lat2_data", evt_data, 8'h41);
    tick();
    deb = 2'b00;
    sb.push_back(8'h81);
    drain(10);

    // Simultaneous rise with rr=0.
    deb = 2'b11;
    sb.push_back(8'h40);
    sb.push_back(8'h41);
    ticks(4);
    deb = 2'b00;
    sb.push_back(8'h80);
    sb.push_back(8'h81);
    drain(10);

    // Long press on btn0.
    deb = 2'b01;
    sb.push_back(8'h40);
`ifdef BTN_EVT_LONG_PRESS_EN
    sb.push_back(8'hC0);
`endif
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 10) chk("long_pre_valid", evt_valid, 0);
      if (t == 11) begin
`ifdef BTN_EVT_LONG_PRESS_EN
        chk("long_valid", evt_valid, 1);
        chk("long_data", evt_data, 8'hC0);
`else
        chk("long_valid", evt_valid, 0);
`endif
      end
    end
    deb = 2'b00;
    sb.push_back(8'h80);
    drain(10);

    // Simultaneous rise with rr=1.
    deb = 2'b11;
    sb.push_back(8'h41);
    sb.push_back(8'h40);
    ticks(4);
    deb = 2'b00;
    sb.push_back(8'h81);
    sb.push_back(8'h80);
    drain(10);

    // Stalled consumer: fill FIFO, hold two pending flags, drop the rest.
    evt_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      deb = 2'b01;
      if (p < 3) sb.push_back(8'h40);
      ticks(2);
      deb = 2'b00;
      if (p < 3) sb.push_back(8'h80);
      ticks(2);
    end
    chk("ovf_valid", evt_valid, 1);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", evt_data, 8'h40);
    ticks(2);
    chk("ovf_head_stable", evt_data, 8'h40);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);
    tick();
    chk("ovf_stays_clear", overflow, 0);
    evt_ready = 1'b1;
    drain(20);

    // Asynchronous reset with queued events.
    evt_ready = 1'b0;
    deb = 2'b11;
    ticks(3);
    deb = 2'b10;
    ticks(3);
    chk("pre_rst_valid", evt_valid, 1);
    arst_n = 1'b0;
    #2;
    chk("async_rst_valid", evt_valid, 0);
    chk("async_rst_data", evt_data, 8'h00);
    chk("async_rst_ovf", overflow, 0);
    ticks(2);
    arst_n    = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_rst_valid[%0d]", i), evt_valid, 0);
    end
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
